// File: rtl/md_sched_pkg.sv
// Shared types and constants for the MD position-read scheduling logic.
package md_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        WAIT_NUM,
        SWEEP,
        FINISH
    } sched_state_t;

    // Address 0 of every cell holds the particle count; particles start here.
    localparam int unsigned PARTICLE_ADDR_BASE = 1;

endpackage

// File: rtl/pos_read_scheduler_if.sv
// Control bus between pos_read_scheduler (master) and pos_data_preprocessor (slave).
interface pos_read_scheduler_if #(
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned NUM_FILTER        = 7
);

    logic                         start;
    logic                         pause_req;
    logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count;
    logic [PARTICLE_ID_WIDTH-1:0] home_particle_count;
    logic [NUM_FILTER-1:0]        reading_done;

    logic                         phase;
    logic [PARTICLE_ID_WIDTH-1:0] ref_id;
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic                         reading_particle_num;
    logic                         pause_reading;
    logic                         busy;
    logic                         done;

    modport master (
        input  start,
        input  pause_req,
        input  ref_particle_count,
        input  home_particle_count,
        input  reading_done,
        output phase,
        output ref_id,
        output particle_id,
        output reading_particle_num,
        output pause_reading,
        output busy,
        output done
    );

    modport slave (
        output start,
        output pause_req,
        output ref_particle_count,
        output home_particle_count,
        output reading_done,
        input  phase,
        input  ref_id,
        input  particle_id,
        input  reading_particle_num,
        input  pause_reading,
        input  busy,
        input  done
    );

endinterface

// File: rtl/sweep_addr_counter.sv
// Nested particle_id / phase / ref_id address counter for the sweep.
// particle_id runs fastest, then phase, then ref_id. Outputs are the registers.
module sweep_addr_counter
    import md_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             run,
    input  logic             hold,
    input  logic [WIDTH-1:0] home_cnt,
    input  logic [WIDTH-1:0] ref_cnt,
    output logic             phase,
    output logic [WIDTH-1:0] ref_id,
    output logic [WIDTH-1:0] particle_id,
    output logic             phase_end,
    output logic             wrap_last
);

    localparam logic [WIDTH-1:0] ADDR_BASE = WIDTH'(PARTICLE_ADDR_BASE);

    // Boundary flags: end of a phase-1 pass, and end of the whole sweep.
    // Equality checks keep ref_cnt at the maximum value from wrapping.
    always_comb begin
        phase_end = phase && (particle_id == home_cnt);
        wrap_last = phase_end && (ref_id == ref_cnt);
    end

    // Address registers: clear wins over load, load over a normal step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= 1'b0;
            ref_id      <= '0;
            particle_id <= '0;
        end else if (clear) begin
            phase       <= 1'b0;
            ref_id      <= '0;
            particle_id <= '0;
        end else if (load) begin
            phase       <= 1'b0;
            ref_id      <= ADDR_BASE;
            particle_id <= ADDR_BASE;
        end else if (run && !hold) begin
            if (particle_id < home_cnt) begin
                particle_id <= particle_id + 1'b1;
            end else begin
                particle_id <= ADDR_BASE;
                phase       <= ~phase;
                if (phase) begin
                    ref_id <= ref_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pos_read_scheduler.sv
// Sequencer driving pos_data_preprocessor: count read, then the full
// ref_id x phase x particle_id sweep. All outputs are registered.
// Optional feature: define POS_READ_SCHED_PERF_EN to add saturating
// sweep_cycles / pause_cycles activity counters.
module pos_read_scheduler
    import md_sched_pkg::*;
#(
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned NUM_FILTER        = 7,
    parameter int unsigned COUNT_LAT         = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef POS_READ_SCHED_PERF_EN
    output logic [31:0] sweep_cycles,
    output logic [31:0] pause_cycles,
`endif
    pos_read_scheduler_if.master bus
);

    localparam int unsigned WAIT_W = (COUNT_LAT > 1) ? $clog2(COUNT_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COUNT_LAT - 1);

    sched_state_t                 state_q;
    logic [WAIT_W-1:0]            wait_q;
    logic [PARTICLE_ID_WIDTH-1:0] ref_cnt_q;
    logic [PARTICLE_ID_WIDTH-1:0] home_cnt_q;
    logic                         rd_num_q;
    logic                         pause_q;
    logic                         busy_q;
    logic                         done_q;

    logic [NUM_FILTER-1:0]        rd_done;
    logic                         wait_last;
    logic                         counts_zero;
    logic                         sweep_end;
    logic                         ctr_load;
    logic                         ctr_run;
    logic                         phase_end;
    logic                         wrap_last;
    logic                         ctr_phase;
    logic [PARTICLE_ID_WIDTH-1:0] ctr_ref_id;
    logic [PARTICLE_ID_WIDTH-1:0] ctr_particle_id;

    assign rd_done = bus.reading_done;

    // Sweep control: only an unpaused cycle may step or end the sweep.
    always_comb begin
        wait_last   = (wait_q == WAIT_LAST);
        counts_zero = (bus.ref_particle_count == '0) || (bus.home_particle_count == '0);
        ctr_load    = (state_q == WAIT_NUM) && wait_last && !counts_zero;
        sweep_end   = (state_q == SWEEP) && !pause_q && (wrap_last || (phase_end && (&rd_done)));
        ctr_run     = (state_q == SWEEP) && !sweep_end;
    end

    sweep_addr_counter #(
        .WIDTH (PARTICLE_ID_WIDTH)
    ) u_addr (
        .clk         (clk),
        .rst         (rst),
        .clear       (sweep_end),
        .load        (ctr_load),
        .run         (ctr_run),
        .hold        (pause_q),
        .home_cnt    (home_cnt_q),
        .ref_cnt     (ref_cnt_q),
        .phase       (ctr_phase),
        .ref_id      (ctr_ref_id),
        .particle_id (ctr_particle_id),
        .phase_end   (phase_end),
        .wrap_last   (wrap_last)
    );

    // Main FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            ref_cnt_q  <= '0;
            home_cnt_q <= '0;
            rd_num_q   <= 1'b0;
            pause_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= RD_NUM;
                        rd_num_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                RD_NUM: begin
                    state_q  <= WAIT_NUM;
                    rd_num_q <= 1'b0;
                    wait_q   <= '0;
                end
                WAIT_NUM: begin
                    if (wait_last) begin
                        ref_cnt_q  <= bus.ref_particle_count;
                        home_cnt_q <= bus.home_particle_count;
                        if (counts_zero) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SWEEP;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_end) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        pause_q <= 1'b0;
                    end else begin
                        pause_q <= bus.pause_req;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    rd_num_q <= 1'b0;
                    pause_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef POS_READ_SCHED_PERF_EN
    // Saturating activity counters, cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cycles <= '0;
            pause_cycles <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            sweep_cycles <= '0;
            pause_cycles <= '0;
        end else if (state_q == SWEEP) begin
            if (sweep_cycles != '1) begin
                sweep_cycles <= sweep_cycles + 1'b1;
            end
            if (pause_q && (pause_cycles != '1)) begin
                pause_cycles <= pause_cycles + 1'b1;
            end
        end
    end
`endif

    assign bus.phase                = ctr_phase;
    assign bus.ref_id               = ctr_ref_id;
    assign bus.particle_id          = ctr_particle_id;
    assign bus.reading_particle_num = rd_num_q;
    assign bus.pause_reading        = pause_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;

endmodule

// File: tb/tb_pos_read_scheduler.sv
// Directed self-checking bench for pos_read_scheduler.
module tb_pos_read_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   done_seen;
    int   rdnum_seen;
    int   d0;
    int   r0;

`ifdef POS_READ_SCHED_PERF_EN
    logic [31:0] sweep_cycles;
    logic [31:0] pause_cycles;
`endif

    pos_read_scheduler_if #(
        .PARTICLE_ID_WIDTH (7),
        .NUM_FILTER        (7)
    ) bus ();

    pos_read_scheduler #(
        .PARTICLE_ID_WIDTH (7),
        .NUM_FILTER        (7),
        .COUNT_LAT         (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef POS_READ_SCHED_PERF_EN
        .sweep_cycles (sweep_cycles),
        .pause_cycles (pause_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done) done_seen++;
        if (bus.reading_particle_num) rdnum_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, reading_particle_num, pause_reading, phase, ref_id, particle_id}
    function automatic logic [18:0] obs_all();
        return {bus.busy, bus.done, bus.reading_particle_num, bus.pause_reading,
                bus.phase, bus.ref_id, bus.particle_id};
    endfunction

    // {pause_reading, ref_id, phase, particle_id}
    function automatic logic [15:0] obs_addr();
        return {bus.pause_reading, bus.ref_id, bus.phase, bus.particle_id};
    endfunction

    // Address of the idx-th unpaused sweep cycle for a given home count.
    function automatic logic [15:0] exp_addr(input int idx, input int home);
        int r;
        int ph;
        int p;
        r  = idx / (2 * home) + 1;
        ph = (idx / home) % 2;
        p  = idx % home + 1;
        return {1'b0, 7'(r), 1'(ph), 7'(p)};
    endfunction

    task automatic start_sweep(input int refc, input int home);
        bus.ref_particle_count  = 7'(refc);
        bus.home_particle_count = 7'(home);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic expect_sweep(input int home, input int n, input string name);
        for (int s = 0; s < n; s++) begin
            check_eq($sformatf("%s_s%0d", name, s), 32'(obs_addr()), 32'(exp_addr(s, home)));
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_seen  = 0;
        rdnum_seen = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pause_req = 1'b0;
        bus.ref_particle_count = '0;
        bus.home_particle_count = '0;
        bus.reading_done = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'(obs_all()), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("idle_outputs", 32'(obs_all()), 32'h0);

        // Basic sweep ref_cnt=2, home_cnt=3; stray start and pause_req outside SWEEP.
        d0 = done_seen;
        r0 = rdnum_seen;
        start_sweep(2, 3);
        check_eq("basic_c1", 32'(obs_all()), 32'h50000);
        bus.pause_req = 1'b1;
        tick();
        check_eq("basic_c2", 32'(obs_all()), 32'h40000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("basic_c3", 32'(obs_all()), 32'h40000);
        tick();
        bus.pause_req = 1'b0;
        expect_sweep(3, 12, "basic");
        check_eq("basic_finish", 32'(obs_all()), 32'h60000);
        tick();
        check_eq("basic_idle", 32'(obs_all()), 32'h0);
        check_eq("basic_done_pulses", 32'(done_seen - d0), 32'd1);
        check_eq("basic_rdnum_cycles", 32'(rdnum_seen - r0), 32'd1);

        // Pause: pause_req high for sweep cycles 4..7.
        start_sweep(2, 3);
        repeat (3) tick();
        for (int s = 0; s < 16; s++) begin
            int idx;
            logic pz;
            bus.pause_req = (s >= 4 && s <= 7);
            idx = (s <= 5) ? s : ((s <= 9) ? 5 : s - 4);
            pz  = (s >= 5 && s <= 8);
            check_eq($sformatf("pause_s%0d", s), 32'(obs_addr()),
                     32'(exp_addr(idx, 3) | {pz, 15'h0}));
            tick();
        end
        bus.pause_req = 1'b0;
        check_eq("pause_finish", 32'(obs_all()), 32'h60000);
`ifdef POS_READ_SCHED_PERF_EN
        check_eq("pause_sweep_cycles", sweep_cycles, 32'd16);
        check_eq("pause_pause_cycles", pause_cycles, 32'd4);
`endif
        tick();

        // Zero home count: done at cycle 4 with no sweep.
        start_sweep(5, 0);
        tick();
        tick();
        check_eq("zero_c3", 32'(obs_all()), 32'h40000);
        tick();
        check_eq("zero_c4_done", 32'(obs_all()), 32'h60000);
        tick();
        check_eq("zero_idle", 32'(obs_all()), 32'h0);

        // Early exit at the end of ref 1 phase 1.
        start_sweep(5, 3);
        repeat (3) tick();
        for (int s = 0; s < 6; s++) begin
            if (s >= 3) bus.reading_done = 7'h7F;
            check_eq($sformatf("early_s%0d", s), 32'(obs_addr()), 32'(exp_addr(s, 3)));
            tick();
        end
        check_eq("early_finish", 32'(obs_all()), 32'h60000);
        bus.reading_done = '0;
        tick();
        check_eq("early_idle", 32'(obs_all()), 32'h0);

        // Asynchronous reset with ref_id=3, then a full replay.
        start_sweep(5, 3);
        repeat (3) tick();
        expect_sweep(3, 12, "rst_pre");
        check_eq("rst_ref3", 32'(bus.ref_id), 32'd3);
        d0 = done_seen;
        #2 rst = 1'b1;
        #1 check_eq("rst_async", 32'(obs_all()), 32'h0);
        #1 rst = 1'b0;
        tick();
        tick();
        check_eq("rst_idle", 32'(obs_all()), 32'h0);
        check_eq("rst_no_done", 32'(done_seen - d0), 32'd0);
        start_sweep(5, 3);
        check_eq("replay_c1", 32'(obs_all()), 32'h50000);
        repeat (3) tick();
        expect_sweep(3, 30, "replay");
        check_eq("replay_finish", 32'(obs_all()), 32'h60000);
        tick();

        // Maximum ref count, home count 1: 254 sweep cycles, no wrap.
        start_sweep(127, 1);
        repeat (3) tick();
        expect_sweep(1, 254, "max");
        check_eq("max_finish", 32'(obs_all()), 32'h60000);
`ifdef POS_READ_SCHED_PERF_EN
        check_eq("max_sweep_cycles", sweep_cycles, 32'd254);
        check_eq("max_pause_cycles", pause_cycles, 32'd0);
`endif
        tick();
        check_eq("max_idle", 32'(obs_all()), 32'h0);
`ifdef POS_READ_SCHED_PERF_EN
        check_eq("max_sweep_hold", sweep_cycles, 32'd254);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
